// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 clock/data
// pins, deserialises 11-bit device-to-host frames and decodes set-2 prefixes
// (E0, F0, E1) into a toggle-strobed 11-bit key word.
// Optional macro PS2_PARITY_CHECK_EN: when defined, odd parity is enforced
// at the stop bit; when undefined, the parity bit is ignored.
module ps2_scancode_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 24000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic        clk_24,
  input  logic        reset,
  input  logic        ps2_kbd_clk,
  input  logic        ps2_kbd_data,
  output logic [10:0] ps2_key,
  output logic        frame_err,
  output logic        busy
);

  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned HIST_W = FILTER_LEN - 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  logic              clk_s1, clk_s2, dat_s1, dat_s2;
  logic [HIST_W-1:0] clk_hist;
  logic              filt_clk;
  logic [FILTER_LEN-1:0] hist_next_c;
  logic              sample_c;

  state_t            state;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_q;
  logic              byte_valid;
  logic [TO_W-1:0]   to_cnt;

  logic              ext_q, brk_q;
  logic [2:0]        skip_cnt;

  logic              timeout_c, start_err_c, stop_bad_c, stop_err_c, err_c;
  logic              is_resp_c;

`ifdef PS2_PARITY_CHECK_EN
  logic              par_q;
`endif

  // Two-flop synchronisers on both pins; idle level is high
  always_ff @(posedge clk_24) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_kbd_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_kbd_data;
      dat_s2 <= dat_s1;
    end
  end

  // Current sample plus history: FILTER_LEN agreeing samples move the filtered clock
  assign hist_next_c = {clk_hist, clk_s2};
  assign sample_c    = filt_clk && (hist_next_c == '0);

  // Glitch filter on the synchronised PS/2 clock
  always_ff @(posedge clk_24) begin
    if (reset) begin
      clk_hist <= '1;
      filt_clk <= 1'b1;
    end else begin
      clk_hist <= hist_next_c[HIST_W-1:0];
      if (&hist_next_c) begin
        filt_clk <= 1'b1;
      end else if (hist_next_c == '0) begin
        filt_clk <= 1'b0;
      end
    end
  end

  // Error sources; any of them abandons the frame and clears the prefix state
`ifdef PS2_PARITY_CHECK_EN
  assign stop_bad_c = !dat_s2 || !(^{shift_q, par_q});
`else
  assign stop_bad_c = !dat_s2;
`endif
  assign timeout_c   = (state != ST_IDLE) && (to_cnt == TO_LAST);
  assign start_err_c = sample_c && (state == ST_IDLE) && dat_s2;
  assign stop_err_c  = sample_c && (state == ST_STOP) && stop_bad_c;
  assign err_c       = timeout_c || start_err_c || stop_err_c;

  // Inter-edge timer: cleared by every sample, counts only while a frame is open
  always_ff @(posedge clk_24) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (sample_c || timeout_c) begin
      to_cnt <= '0;
    end else if ((state != ST_IDLE) && (to_cnt != TO_LAST)) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Frame FSM: advances on sample events, timeout forces it back to idle
  always_ff @(posedge clk_24) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      bit_cnt    <= 3'd0;
      shift_q    <= 8'd0;
      byte_valid <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      frame_err  <= err_c;
      byte_valid <= 1'b0;
      if (timeout_c) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else if (sample_c) begin
        case (state)
          ST_IDLE: begin
            if (!dat_s2) begin
              state   <= ST_DATA;
              busy    <= 1'b1;
              bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            shift_q <= {dat_s2, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_q <= dat_s2;
`endif
            state <= ST_STOP;
          end
          ST_STOP: begin
            byte_valid <= !stop_bad_c;
            state      <= ST_IDLE;
            busy       <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Device response bytes that carry no key information
  always_comb begin
    is_resp_c = 1'b0;
    case (shift_q)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_resp_c = 1'b1;
      default:                                         is_resp_c = 1'b0;
    endcase
  end

  // Set-2 prefix decode and toggle-strobed key output
  always_ff @(posedge clk_24) begin
    if (reset) begin
      ps2_key  <= 11'd0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      skip_cnt <= 3'd0;
    end else if (err_c) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      skip_cnt <= 3'd0;
    end else if (byte_valid) begin
      if (skip_cnt != 3'd0) begin
        skip_cnt <= skip_cnt - 3'd1;
      end else if (shift_q == 8'hE1) begin
        skip_cnt <= 3'd7;
      end else if (shift_q == 8'hE0) begin
        ext_q <= 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_q <= 1'b1;
      end else if (!ext_q && !brk_q && is_resp_c) begin
        ps2_key <= ps2_key;
      end else begin
        ps2_key <= {~ps2_key[10], ~brk_q, ext_q, shift_q};
        ext_q   <= 1'b0;
        brk_q   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: frames are bit-banged on the pins and
// key word, error pulses, toggles and busy are compared to hand-worked values.
module tb_ps2_scancode_rx;

  localparam int unsigned TIMEOUT_CYCLES = 24000;
  localparam int unsigned FILTER_LEN     = 8;
  localparam int unsigned HALF           = 20;

`ifdef PS2_PARITY_CHECK_EN
  localparam logic [10:0] K3  = 11'h175;
  localparam logic [10:0] K4  = 11'h616;
  localparam logic [10:0] K5  = 11'h21C;
  localparam logic [10:0] K5B = 11'h41C;
  localparam logic [10:0] K6  = 11'h229;
  localparam int          E3  = 1;
  localparam int          T3  = 0;
`else
  localparam logic [10:0] K3  = 11'h61C;
  localparam logic [10:0] K4  = 11'h216;
  localparam logic [10:0] K5  = 11'h61C;
  localparam logic [10:0] K5B = 11'h01C;
  localparam logic [10:0] K6  = 11'h629;
  localparam int          E3  = 0;
  localparam int          T3  = 1;
`endif

  logic        clk_24 = 1'b0;
  logic        reset;
  logic        ps2_kbd_clk;
  logic        ps2_kbd_data;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int tog_cnt  = 0;
  int err_cnt  = 0;
  int busy_cyc = 0;
  logic prev_tog = 1'b0;
  int t0, e0, b0;

  always #21 clk_24 = ~clk_24;

  ps2_scancode_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .FILTER_LEN    (FILTER_LEN)
  ) dut (
    .clk_24      (clk_24),
    .reset       (reset),
    .ps2_kbd_clk (ps2_kbd_clk),
    .ps2_kbd_data(ps2_kbd_data),
    .ps2_key     (ps2_key),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  // Event monitor: key toggles, error pulses and busy cycles
  always @(negedge clk_24) begin
    if (reset) begin
      prev_tog <= 1'b0;
    end else begin
      if (ps2_key[10] != prev_tog) tog_cnt <= tog_cnt + 1;
      prev_tog <= ps2_key[10];
      if (frame_err) err_cnt <= err_cnt + 1;
      if (busy) busy_cyc <= busy_cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_24);
    #1;
  endtask

  task automatic ps2_bit(input logic d);
    ps2_kbd_data = d;
    wait_cyc(HALF);
    ps2_kbd_clk = 1'b0;
    wait_cyc(HALF);
    ps2_kbd_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    ps2_kbd_data = 1'b1;
    wait_cyc(2 * HALF);
  endtask

  initial begin
    logic [10:0] f1;
    reset        = 1'b1;
    ps2_kbd_clk  = 1'b1;
    ps2_kbd_data = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(FILTER_LEN + 4);
    check("rst_key", 32'(ps2_key), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // 1: make 0x1C with exact output latency
    f1 = {1'b1, 1'b0, 8'h1C, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(f1[i]);
    ps2_kbd_data = f1[10];
    wait_cyc(HALF);
    ps2_kbd_clk = 1'b0;
    wait_cyc(10);
    check("t1_before", 32'(ps2_key), 32'h0);
    wait_cyc(1);
    check("t1_key", 32'(ps2_key), 32'h61C);
    wait_cyc(HALF - 11);
    ps2_kbd_clk = 1'b1;
    ps2_kbd_data = 1'b1;
    wait_cyc(2 * HALF);
    check("t1_err", 32'(err_cnt), 32'd0);
    check("t1_tog", 32'(tog_cnt), 32'd1);

    // 2: E0 F0 75 -> one extended break event
    t0 = tog_cnt;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    check("t2_prefix_key", 32'(ps2_key), 32'h61C);
    check("t2_prefix_tog", 32'(tog_cnt - t0), 32'd0);
    send_frame(8'h75, 1'b0, 1'b0);
    check("t2_key", 32'(ps2_key), 32'h175);
    check("t2_tog", 32'(tog_cnt - t0), 32'd1);

    // 3: 0x1C with a wrong parity bit
    t0 = tog_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    check("t3_key", 32'(ps2_key), 32'(K3));
    check("t3_err", 32'(err_cnt - e0), 32'(E3));
    check("t3_tog", 32'(tog_cnt - t0), 32'(T3));

    // 4: E0 then a frame stalled after 4 data bits; timeout clears E0
    send_frame(8'hE0, 1'b0, 1'b0);
    e0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_kbd_data = 1'b1;
    wait_cyc(5);
    check("t4_busy_mid", 32'(busy), 32'h1);
    wait_cyc(TIMEOUT_CYCLES + 10);
    check("t4_err", 32'(err_cnt - e0), 32'd1);
    check("t4_busy_end", 32'(busy), 32'h0);
    t0 = tog_cnt;
    send_frame(8'h16, 1'b0, 1'b0);
    check("t4_key", 32'(ps2_key), 32'(K4));
    check("t4_tog", 32'(tog_cnt - t0), 32'd1);

    // 5: clock glitch one sample short of the filter length
    e0 = err_cnt; b0 = busy_cyc;
    ps2_kbd_data = 1'b0;
    ps2_kbd_clk  = 1'b0;
    wait_cyc(FILTER_LEN - 1);
    ps2_kbd_clk  = 1'b1;
    wait_cyc(30);
    ps2_kbd_data = 1'b1;
    wait_cyc(10);
    check("t5_busy", 32'(busy_cyc - b0), 32'd0);
    check("t5_err", 32'(err_cnt - e0), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t5_key", 32'(ps2_key), 32'(K5));

    // Start bit high in idle, then a bad stop bit: errors, no output
    e0 = err_cnt; t0 = tog_cnt; b0 = busy_cyc;
    ps2_bit(1'b1);
    wait_cyc(2 * HALF);
    check("start_err", 32'(err_cnt - e0), 32'd1);
    check("start_busy", 32'(busy_cyc - b0), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("stop_err", 32'(err_cnt - e0), 32'd2);
    check("stop_tog", 32'(tog_cnt - t0), 32'd0);

    // Device response AA is dropped; F0 1C is a plain break
    send_frame(8'hAA, 1'b0, 1'b0);
    check("resp_tog", 32'(tog_cnt - t0), 32'd0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    check("brk_key", 32'(ps2_key), 32'(K5B));

    // 6: pause sequence swallowed, then 0x29
    t0 = tog_cnt;
    send_frame(8'hE1, 1'b0, 1'b0);
    send_frame(8'h14, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0);
    send_frame(8'hE1, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h14, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0);
    check("t6_skip_tog", 32'(tog_cnt - t0), 32'd0);
    send_frame(8'h29, 1'b0, 1'b0);
    check("t6_key", 32'(ps2_key), 32'(K6));
    check("t6_tog", 32'(tog_cnt - t0), 32'd1);

    // Reset mid-frame: frame abandoned silently
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_kbd_data = 1'b1;
    wait_cyc(2);
    check("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(1);
    check("mid_key", 32'(ps2_key), 32'h0);
    check("mid_busy_rst", 32'(busy), 32'h0);
    wait_cyc(TIMEOUT_CYCLES / 100);
    check("mid_err", 32'(err_cnt - e0), 32'd0);
    check("mid_busy_after", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
